// File: rtl/lcd_refresh_sched_if.sv
// Byte handshake between the LCD refresh scheduler and the LCD bus engine.
// The master offers one byte at a time (rs selects instruction/data).
// The slave takes that byte on a rising clock edge while both valid and ready are high.
interface lcd_refresh_sched_if;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_rs,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_rs,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/lcd_refresh_sched.sv
// LCD refresh scheduler for a 16x2 HD44780 character display.
// After reset it waits for the panel to power up, then sends the init command sequence.
// It keeps a 32-character shadow buffer with one dirty bit per position.
// It writes only the changed characters, each as a DDRAM set-address plus data byte pair.
// The set-address byte is skipped when the LCD cursor already points at the next position.
module lcd_refresh_sched #(
  parameter int POWERUP_CYCLES = 50000,
  parameter int CLEAR_CYCLES   = 5000,
  parameter int CNT_W          = 16
) (
  input  logic                       clk,
  input  logic                       sysrst,
  input  logic                       update,
  input  logic [4:0]                 position,
  input  logic [7:0]                 upd_char,
  input  logic                       refresh_all,
  output logic                       init_done,
  lcd_refresh_sched_if.master        cmd
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    CLR_WAIT,
    SCAN,
    SET_ADDR,
    WR_DATA
  } state_t;

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [4:0]       ptr_q, ptr_d;
  logic [4:0]       pos_q, pos_d;
  logic [7:0]       char_q, char_d;
  logic [4:0]       cursor_q, cursor_d;
  logic             cur_vld_q, cur_vld_d;
  logic             valid_q, valid_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic [31:0]      dirty_q, dirty_d;
  logic [7:0]       buf_q [32];

  // Init command bytes in issue order: 8-bit/2-line, display on, clear, entry mode increment.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Shadow character buffer; updates land in every state, including before init finishes.
  always_ff @(posedge clk or negedge sysrst) begin
    if (!sysrst) begin
      for (int i = 0; i < 32; i++) begin
        buf_q[i] <= 8'h20;
      end
    end else if (update) begin
      buf_q[position] <= upd_char;
    end
  end

  // State register plus every piece of scheduler state that the next-state logic computes.
  always_ff @(posedge clk or negedge sysrst) begin
    if (!sysrst) begin
      state_q   <= PWR_WAIT;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      ptr_q     <= 5'd0;
      pos_q     <= 5'd0;
      char_q    <= 8'h00;
      cursor_q  <= 5'd0;
      cur_vld_q <= 1'b0;
      valid_q   <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      dirty_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      pos_q     <= pos_d;
      char_q    <= char_d;
      cursor_q  <= cursor_d;
      cur_vld_q <= cur_vld_d;
      valid_q   <= valid_d;
      rs_q      <= rs_d;
      data_q    <= data_d;
      done_q    <= done_d;
      dirty_q   <= dirty_d;
    end
  end

  // Next-state logic. An issuing state raises valid only while valid is low, so the offered byte never changes.
  // Dropping valid on acceptance forces one idle cycle between bytes.
  // Dirty bits are set after the scan clears them, so a same-cycle update wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    pos_d     = pos_q;
    char_d    = char_q;
    cursor_d  = cursor_q;
    cur_vld_d = cur_vld_q;
    valid_d   = valid_q;
    rs_d      = rs_q;
    data_d    = data_q;
    done_d    = done_q;
    dirty_d   = dirty_q;

    unique case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d = INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      INIT: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          rs_d    = 1'b0;
          data_d  = init_byte(idx_q);
        end else if (cmd.cmd_ready) begin
          valid_d = 1'b0;
          case (idx_q)
            2'd2: begin
              state_d = CLR_WAIT;
              cnt_d   = '0;
              idx_d   = 2'd3;
            end
            2'd3: begin
              state_d = SCAN;
              done_d  = 1'b1;
            end
            default: idx_d = idx_q + 2'd1;
          endcase
        end
      end

      CLR_WAIT: begin
        if (cnt_q == CLR_LAST) begin
          state_d = INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SCAN: begin
        if (dirty_q[ptr_q]) begin
          pos_d            = ptr_q;
          char_d           = buf_q[ptr_q];
          dirty_d[ptr_q]   = 1'b0;
          if (cur_vld_q && (cursor_q == ptr_q)) begin
            state_d = WR_DATA;
          end else begin
            state_d = SET_ADDR;
          end
        end else begin
          ptr_d = ptr_q + 5'd1;
        end
      end

      SET_ADDR: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          rs_d    = 1'b0;
          data_d  = {1'b1, pos_q[4], 2'b00, pos_q[3:0]};
        end else if (cmd.cmd_ready) begin
          valid_d = 1'b0;
          state_d = WR_DATA;
        end
      end

      WR_DATA: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          rs_d    = 1'b1;
          data_d  = char_q;
        end else if (cmd.cmd_ready) begin
          valid_d   = 1'b0;
          state_d   = SCAN;
          ptr_d     = pos_q + 5'd1;
          cursor_d  = pos_q + 5'd1;
          cur_vld_d = (pos_q[3:0] != 4'hF);
        end
      end

      default: begin
        state_d = PWR_WAIT;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    if (refresh_all) begin
      dirty_d = '1;
    end
    if (update) begin
      dirty_d[position] = 1'b1;
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_rs    = rs_q;
  assign cmd.cmd_data  = data_q;
  assign init_done     = done_q;

endmodule

// File: tb/tb_lcd_refresh_sched.sv
// Testbench for lcd_refresh_sched.
// A monitor emulates the LCD controller: it checks the init sequence, DDRAM address/data semantics and
// handshake stability.
// Directed tests compare the accepted byte stream against hand-computed sequences.
module tb_lcd_refresh_sched;
  localparam int PWR = 20;
  localparam int CLR = 10;

  logic       clk = 1'b0;
  logic       sysrst;
  logic       update;
  logic [4:0] position;
  logic [7:0] upd_char;
  logic       refresh_all;
  logic       init_done;

  lcd_refresh_sched_if bus();

  lcd_refresh_sched #(
    .POWERUP_CYCLES(PWR),
    .CLEAR_CYCLES  (CLR),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .sysrst     (sysrst),
    .update     (update),
    .position   (position),
    .upd_char   (upd_char),
    .refresh_all(refresh_all),
    .init_done  (init_done),
    .cmd        (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] modelBuf [32];
  logic [7:0] lcdDisp  [32];
  logic [7:0] initSeq  [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  int         lcdAddr;
  logic       lcdAddrOk;
  int         initCount;
  logic       expDone;
  int         cyc;
  int         clrAccCyc;
  logic       prevValid, prevReady, prevRs, prevAcc, monAcc;
  logic [7:0] prevData;
  logic [8:0] streamQ [$];
  logic [8:0] expQ [$];

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter since reset release, used to check the power-up and clear waits.
  always @(posedge clk or negedge sysrst) begin
    if (!sysrst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // LCD controller emulation for one accepted byte.
  task automatic handleByte(input logic rs, input logic [7:0] data);
    streamQ.push_back({rs, data});
    if (initCount < 4) begin
      checkOutput("init_rs", rs, 1'b0);
      checkOutput("init_byte", data, initSeq[initCount]);
      if (initCount == 0) checkOutput("powerup_wait", cyc >= PWR, 1'b1);
      if (initCount == 3) checkOutput("clear_wait", (cyc - clrAccCyc) >= CLR, 1'b1);
      if (initCount == 2) begin
        clrAccCyc = cyc;
        for (int i = 0; i < 32; i++) lcdDisp[i] = 8'h20;
        lcdAddrOk = 1'b0;
      end
      initCount++;
      if (initCount == 4) expDone = 1'b1;
    end else if (!rs) begin
      checkOutput("addr_cmd", data[7] && (data[5:4] == 2'b00), 1'b1);
      lcdAddr   = (data[6] ? 16 : 0) + int'(data[3:0]);
      lcdAddrOk = 1'b1;
    end else begin
      checkOutput("data_addr_ok", lcdAddrOk, 1'b1);
      if (lcdAddrOk) begin
        lcdDisp[lcdAddr] = data;
        if (lcdAddr % 16 == 15) lcdAddrOk = 1'b0;
        else                    lcdAddr++;
      end
    end
  endtask

  // Per-cycle compare process, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (!sysrst) begin
      checkOutput("rst_valid", bus.cmd_valid, 1'b0);
      checkOutput("rst_done", init_done, 1'b0);
      initCount = 0;
      expDone   = 1'b0;
      prevValid = 1'b0;
      prevReady = 1'b0;
      prevAcc   = 1'b0;
      lcdAddrOk = 1'b0;
    end else begin
      checkOutput("init_done", init_done, expDone);
      if (prevValid && !prevReady) begin
        checkOutput("hold_valid", bus.cmd_valid, 1'b1);
        checkOutput("hold_byte", {bus.cmd_rs, bus.cmd_data}, {prevRs, prevData});
      end
      if (prevAcc) checkOutput("gap_valid", bus.cmd_valid, 1'b0);
      monAcc = bus.cmd_valid && bus.cmd_ready;
      if (monAcc) handleByte(bus.cmd_rs, bus.cmd_data);
      prevValid = bus.cmd_valid;
      prevReady = bus.cmd_ready;
      prevRs    = bus.cmd_rs;
      prevData  = bus.cmd_data;
      prevAcc   = monAcc;
    end
  end

  // Stimulus tasks are all entered 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [4:0] p, input logic [7:0] c);
    update      = 1'b1;
    position    = p;
    upd_char    = c;
    modelBuf[p] = c;
    @(posedge clk); #1;
    update = 1'b0;
  endtask

  task automatic doRefresh();
    refresh_all = 1'b1;
    @(posedge clk); #1;
    refresh_all = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int idle = 0;
    for (int k = 0; k < 3000 && idle < 80; k++) begin
      @(posedge clk); #1;
      if (bus.cmd_valid) idle = 0;
      else               idle++;
    end
    checkOutput({name, "_idle"}, idle >= 80, 1'b1);
  endtask

  task automatic waitValid(input string name);
    int k = 0;
    while (!bus.cmd_valid && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput({name, "_valid_seen"}, bus.cmd_valid, 1'b1);
  endtask

  // Raise ready for exactly n acceptances; optionally lower it right after the last one.
  task automatic releaseFor(input int n, input logic dropAfter);
    int got = 0;
    bus.cmd_ready = 1'b1;
    for (int k = 0; k < 500 && got < n; k++) begin
      @(negedge clk);
      if (bus.cmd_valid) got++;
      @(posedge clk); #1;
    end
    if (dropAfter) bus.cmd_ready = 1'b0;
    checkOutput("release_count", got, n);
  endtask

  task automatic checkStream(input string name);
    checkOutput({name, "_len"}, streamQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < streamQ.size(); i++)
      checkOutput($sformatf("%s_byte%0d", name, i), streamQ[i], expQ[i]);
  endtask

  task automatic checkDisplay(input string name);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("%s_disp%0d", name, i), lcdDisp[i], modelBuf[i]);
  endtask

  task automatic pushInit();
    expQ.delete();
    expQ.push_back(9'h038);
    expQ.push_back(9'h00C);
    expQ.push_back(9'h001);
    expQ.push_back(9'h006);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    sysrst        = 1'b0;
    update        = 1'b0;
    refresh_all   = 1'b0;
    position      = 5'd0;
    upd_char      = 8'h00;
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      modelBuf[i] = 8'h20;
      lcdDisp[i]  = 8'h20;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", bus.cmd_valid, 1'b0);
    checkOutput("reset_rs", bus.cmd_rs, 1'b0);
    checkOutput("reset_data", bus.cmd_data, 8'h00);
    checkOutput("reset_done", init_done, 1'b0);

    // Test 1: init sequence.
    $display("[TB] test 1: init sequence");
    streamQ.delete();
    sysrst = 1'b1;
    pushInit();
    waitIdle("t1");
    checkStream("t1");
    checkOutput("t1_done", init_done, 1'b1);

    // Test 2: address then data, then cursor continuation.
    $display("[TB] test 2: single writes and skip rule");
    streamQ.delete();
    applyStimulus(5'd5, 8'h41);
    waitIdle("t2a");
    expQ = '{9'h085, 9'h141};
    checkStream("t2a");
    streamQ.delete();
    applyStimulus(5'd6, 8'h42);
    waitIdle("t2b");
    expQ = '{9'h142};
    checkStream("t2b");
    checkDisplay("t2");

    // Tests 3 and 4: stall on 0x85, queue col 15 and line 2 col 0 meanwhile.
    $display("[TB] test 3/4: back-pressure and no line wrap");
    streamQ.delete();
    bus.cmd_ready = 1'b0;
    applyStimulus(5'd5, 8'h44);
    waitValid("t4");
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checkOutput("t4_hold", {bus.cmd_valid, bus.cmd_rs, bus.cmd_data}, {1'b1, 1'b0, 8'h85});
    end
    applyStimulus(5'd15, 8'h5A);
    applyStimulus(5'd16, 8'h61);
    bus.cmd_ready = 1'b1;
    waitIdle("t3");
    expQ = '{9'h085, 9'h144, 9'h08F, 9'h15A, 9'h0C0, 9'h161};
    checkStream("t3");
    checkDisplay("t3");

    // Test 5: coalescing, then an update landing on the same cycle the scan clears it.
    $display("[TB] test 5: coalesce and same-cycle set/clear");
    streamQ.delete();
    bus.cmd_ready = 1'b0;
    applyStimulus(5'd20, 8'h55);
    waitValid("t5");
    applyStimulus(5'd3, 8'h31);
    applyStimulus(5'd3, 8'h32);
    applyStimulus(5'd2, 8'h22);
    releaseFor(3, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    releaseFor(1, 1'b0);
    applyStimulus(5'd3, 8'h32);
    waitIdle("t5");
    expQ = '{9'h0C4, 9'h155, 9'h082, 9'h122, 9'h132, 9'h083, 9'h132};
    checkStream("t5");
    checkDisplay("t5");

    // Test 6: refresh queued during power-up, reset mid-flush, then clean re-init.
    $display("[TB] test 6: refresh_all and reset mid-sequence");
    sysrst = 1'b0;
    for (int i = 0; i < 32; i++) modelBuf[i] = 8'h20;
    @(posedge clk); #1;
    streamQ.delete();
    sysrst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    doRefresh();
    pushInit();
    expQ.push_back(9'h080);
    for (int i = 0; i < 16; i++) expQ.push_back(9'h120);
    expQ.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) expQ.push_back(9'h120);
    for (int k = 0; k < 2000 && !(streamQ.size() >= 12 && bus.cmd_valid); k++) begin
      @(posedge clk); #1;
    end
    checkOutput("t6_prefix_len", streamQ.size() >= 12, 1'b1);
    for (int i = 0; i < streamQ.size() && i < expQ.size(); i++)
      checkOutput($sformatf("t6_prefix%0d", i), streamQ[i], expQ[i]);
    checkOutput("t6_valid_before", bus.cmd_valid, 1'b1);
    #2;
    sysrst = 1'b0;
    #1;
    checkOutput("t6_rst_valid", bus.cmd_valid, 1'b0);
    checkOutput("t6_rst_done", init_done, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    streamQ.delete();
    sysrst = 1'b1;
    pushInit();
    waitIdle("t6");
    checkStream("t6");
    checkOutput("t6_done", init_done, 1'b1);
    checkDisplay("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
